// File: rtl/ooo_pkg.sv
// ooo_pkg: widths and payload types shared by rename and the reorder buffer.
//   AREG_W     architectural register index width
//   PREG_W     physical register index width (preg 0 = no destination)
//   ROB_DEPTH  reorder buffer entries; matches the rename free-list depth
//   rob_entry_t  per-entry ROB storage
package ooo_pkg;

    localparam int unsigned AREG_W    = 6;
    localparam int unsigned PREG_W    = 7;
    localparam int unsigned ROB_DEPTH = 16;
    localparam int unsigned ROB_IDX_W = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [AREG_W-1:0] a_rd;
        logic [PREG_W-1:0] p_rd_new;
        logic [PREG_W-1:0] p_rd_old;
    } rob_entry_t;

endpackage

// File: rtl/rob_age_cmp.sv
// rob_age_cmp: program-order comparison of two ROB indices.
//   head            current oldest index (age reference)
//   a, b            indices to compare
//   a_older_than_b  1 when (a - head) mod DEPTH < (b - head) mod DEPTH
module rob_age_cmp
    import ooo_pkg::*;
#(
    parameter int unsigned IDX_W = ROB_IDX_W
) (
    input  logic [IDX_W-1:0] head,
    input  logic [IDX_W-1:0] a,
    input  logic [IDX_W-1:0] b,
    output logic             a_older_than_b
);

    logic [IDX_W-1:0] age_a;
    logic [IDX_W-1:0] age_b;

    // Modular subtraction gives age relative to head.
    assign age_a          = a - head;
    assign age_b          = b - head;
    assign a_older_than_b = (age_a < age_b);

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer behind register rename.
//   disp_*      one renamed instruction per cycle in; disp_idx returns the allocated slot
//   wb_*        completion / branch mispredict from writeback
//   commit_*    in-order retirement of the head entry to rename
//   rollback_*  mispredict walk-back, two entries per cycle (_1 is older than _0)
//   flush_done  one-cycle pulse when the walk-back has reached the branch
// Optional: define ROB_PERF_CNT_EN to add perf_commit_cnt / perf_squash_cnt outputs.
// Outputs are combinational from registered state. Reset is synchronous, active-high.
module reorder_buffer
    import ooo_pkg::*;
#(
    parameter int unsigned DEPTH = ROB_DEPTH,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [AREG_W-1:0] disp_A_rd,
    input  logic [PREG_W-1:0] disp_P_rd_new,
    input  logic [PREG_W-1:0] disp_P_rd_old,
    output logic [IDX_W-1:0]  disp_idx,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_idx,
    input  logic              wb_mispredict,
    output logic              commit_valid,
    output logic              commit_wb_en,
    output logic [AREG_W-1:0] commit_A_rd,
    output logic [PREG_W-1:0] commit_P_rd_new,
    output logic [PREG_W-1:0] commit_P_rd_old,
    output logic              rollback_en_0,
    output logic              rollback_en_1,
    output logic [AREG_W-1:0] rollback_A_rd_0,
    output logic [AREG_W-1:0] rollback_A_rd_1,
    output logic [PREG_W-1:0] rollback_P_rd_old_0,
    output logic [PREG_W-1:0] rollback_P_rd_old_1,
    output logic [PREG_W-1:0] rollback_P_rd_new_0,
    output logic [PREG_W-1:0] rollback_P_rd_new_1,
    output logic              flush_done
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_commit_cnt,
    output logic [31:0]       perf_squash_cnt
`endif
);

    typedef enum logic {
        RUN      = 1'b0,
        ROLLBACK = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    rob_entry_t       rob [DEPTH];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W-1:0] tail_m1;
    logic [IDX_W-1:0] tail_m2;
    logic [IDX_W-1:0] flush_idx;
    logic [IDX_W:0]   count;
    logic             flush_gone;
    logic             full;
    logic             wb_older_tail;
    logic             wb_older_flush;
    logic             wb_live;
    logic             retarget;
    logic             accept;
    logic [1:0]       squash_n;

    assign tail_m1 = tail - IDX_W'(1);
    assign tail_m2 = tail - IDX_W'(2);
    assign full    = (count == (IDX_W+1)'(DEPTH));

    // Live check: when not full, age(wb_idx) < count is the same as age(wb_idx) < age(tail).
    rob_age_cmp #(.IDX_W(IDX_W)) u_live_cmp (
        .head           (head),
        .a              (wb_idx),
        .b              (tail),
        .a_older_than_b (wb_older_tail)
    );

    // A mispredict older than the current flush point moves the walk-back target.
    rob_age_cmp #(.IDX_W(IDX_W)) u_flush_cmp (
        .head           (head),
        .a              (wb_idx),
        .b              (flush_idx),
        .a_older_than_b (wb_older_flush)
    );

    assign wb_live = wb_valid && (full || wb_older_tail);
    // flush_gone: branch retired as it mispredicted, so every live entry is younger than it.
    assign retarget = wb_live && wb_mispredict && !flush_gone && wb_older_flush;

    // Next-state and control outputs.
    always_comb begin
        state_nxt     = state;
        disp_ready    = 1'b0;
        commit_valid  = 1'b0;
        rollback_en_0 = 1'b0;
        rollback_en_1 = 1'b0;
        flush_done    = 1'b0;
        case (state)
            RUN: begin
                disp_ready   = !full;
                commit_valid = (count != '0) && rob[head].valid && rob[head].done;
                if (wb_live && wb_mispredict) begin
                    state_nxt = ROLLBACK;
                end
            end
            ROLLBACK: begin
                // Entries between flush_idx and tail are exactly the ones to squash.
                rollback_en_0 = (tail_m1 != flush_idx);
                rollback_en_1 = rollback_en_0 && (tail_m2 != flush_idx);
                flush_done    = !rollback_en_0;
                if (flush_done && !retarget) begin
                    state_nxt = RUN;
                end
            end
        endcase
    end

    assign accept   = disp_valid && disp_ready;
    assign squash_n = {1'b0, rollback_en_0} + {1'b0, rollback_en_1};
    assign disp_idx = tail;

    assign commit_wb_en        = commit_valid && (rob[head].p_rd_new != '0);
    assign commit_A_rd         = rob[head].a_rd;
    assign commit_P_rd_new     = rob[head].p_rd_new;
    assign commit_P_rd_old     = rob[head].p_rd_old;
    assign rollback_A_rd_0     = rob[tail_m1].a_rd;
    assign rollback_P_rd_new_0 = rob[tail_m1].p_rd_new;
    assign rollback_P_rd_old_0 = rob[tail_m1].p_rd_old;
    assign rollback_A_rd_1     = rob[tail_m2].a_rd;
    assign rollback_P_rd_new_1 = rob[tail_m2].p_rd_new;
    assign rollback_P_rd_old_1 = rob[tail_m2].p_rd_old;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Entry storage, pointers and flush bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                rob[i] <= '0;
            end
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            flush_idx  <= '0;
            flush_gone <= 1'b0;
        end else begin
            if (wb_live) begin
                rob[wb_idx].done <= 1'b1;
            end
            if (state == RUN) begin
                if (commit_valid) begin
                    rob[head].valid <= 1'b0;
                    head            <= head + IDX_W'(1);
                end
                if (accept) begin
                    rob[tail] <= '{valid: 1'b1, done: 1'b0, a_rd: disp_A_rd,
                                   p_rd_new: disp_P_rd_new, p_rd_old: disp_P_rd_old};
                    tail      <= tail + IDX_W'(1);
                end
                count <= count + (IDX_W+1)'(accept) - (IDX_W+1)'(commit_valid);
                if (wb_live && wb_mispredict) begin
                    flush_idx  <= wb_idx;
                    flush_gone <= commit_valid && (wb_idx == head);
                end
            end else begin
                if (rollback_en_0) begin
                    rob[tail_m1].valid <= 1'b0;
                end
                if (rollback_en_1) begin
                    rob[tail_m2].valid <= 1'b0;
                end
                tail  <= tail - IDX_W'(squash_n);
                count <= count - (IDX_W+1)'(squash_n);
                if (retarget) begin
                    flush_idx <= wb_idx;
                end
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    // Free-running, wrapping event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commit_cnt <= '0;
            perf_squash_cnt <= '0;
        end else begin
            perf_commit_cnt <= perf_commit_cnt + 32'(commit_valid);
            perf_squash_cnt <= perf_squash_cnt + 32'(squash_n);
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard bench for reorder_buffer. A program-order queue model
// predicts each cycle's status, retirements and squashes; a monitor compares them.
module tb_reorder_buffer;
    import ooo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_valid;
    logic        disp_ready;
    logic [5:0]  disp_A_rd;
    logic [6:0]  disp_P_rd_new;
    logic [6:0]  disp_P_rd_old;
    logic [3:0]  disp_idx;
    logic        wb_valid;
    logic [3:0]  wb_idx;
    logic        wb_mispredict;
    logic        commit_valid;
    logic        commit_wb_en;
    logic [5:0]  commit_A_rd;
    logic [6:0]  commit_P_rd_new;
    logic [6:0]  commit_P_rd_old;
    logic        rollback_en_0;
    logic        rollback_en_1;
    logic [5:0]  rollback_A_rd_0;
    logic [5:0]  rollback_A_rd_1;
    logic [6:0]  rollback_P_rd_old_0;
    logic [6:0]  rollback_P_rd_old_1;
    logic [6:0]  rollback_P_rd_new_0;
    logic [6:0]  rollback_P_rd_new_1;
    logic        flush_done;
`ifdef ROB_PERF_CNT_EN
    logic [31:0] perf_commit_cnt;
    logic [31:0] perf_squash_cnt;
`endif

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk                 (clk),
        .rst                 (rst),
        .disp_valid          (disp_valid),
        .disp_ready          (disp_ready),
        .disp_A_rd           (disp_A_rd),
        .disp_P_rd_new       (disp_P_rd_new),
        .disp_P_rd_old       (disp_P_rd_old),
        .disp_idx            (disp_idx),
        .wb_valid            (wb_valid),
        .wb_idx              (wb_idx),
        .wb_mispredict       (wb_mispredict),
        .commit_valid        (commit_valid),
        .commit_wb_en        (commit_wb_en),
        .commit_A_rd         (commit_A_rd),
        .commit_P_rd_new     (commit_P_rd_new),
        .commit_P_rd_old     (commit_P_rd_old),
        .rollback_en_0       (rollback_en_0),
        .rollback_en_1       (rollback_en_1),
        .rollback_A_rd_0     (rollback_A_rd_0),
        .rollback_A_rd_1     (rollback_A_rd_1),
        .rollback_P_rd_old_0 (rollback_P_rd_old_0),
        .rollback_P_rd_old_1 (rollback_P_rd_old_1),
        .rollback_P_rd_new_0 (rollback_P_rd_new_0),
        .rollback_P_rd_new_1 (rollback_P_rd_new_1),
        .flush_done          (flush_done)
`ifdef ROB_PERF_CNT_EN
        ,
        .perf_commit_cnt     (perf_commit_cnt),
        .perf_squash_cnt     (perf_squash_cnt)
`endif
    );

    typedef struct {
        int         seq;
        logic [3:0] idx;
        logic [5:0] a;
        logic [6:0] pn;
        logic [6:0] po;
        bit         done;
    } ment_t;

    typedef struct {
        logic [5:0] a;
        logic [6:0] pn;
        logic [6:0] po;
    } pay_t;

    typedef struct {
        bit         ready;
        logic [3:0] idx;
        bit         cv;
        bit         en0;
        bit         en1;
        bit         fd;
    } stat_t;

    // Model: in-flight instructions oldest first, tagged with a program-order sequence.
    ment_t mq[$];
    pay_t  exp_com[$];
    pay_t  exp_sq[$];
    stat_t exp_st[$];
    int    m_tail = 0;
    int    m_seq  = 0;
    bit    m_rb   = 0;
    int    m_fs   = 0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle status, plus payload pops whenever the DUT presents an event.
    initial begin
        stat_t s;
        pay_t  p;
        forever begin
            @(negedge clk);
            #1;
            if (exp_st.size() > 0) begin
                s = exp_st.pop_front();
                chk("disp_ready", 32'(disp_ready), 32'(s.ready));
                chk("disp_idx", 32'(disp_idx), 32'(s.idx));
                chk("commit_valid", 32'(commit_valid), 32'(s.cv));
                chk("rollback_en_0", 32'(rollback_en_0), 32'(s.en0));
                chk("rollback_en_1", 32'(rollback_en_1), 32'(s.en1));
                chk("flush_done", 32'(flush_done), 32'(s.fd));
                if (commit_valid === 1'b1) begin
                    if (exp_com.size() == 0) begin
                        chk("commit_unexpected", 32'(1), 32'(0));
                    end else begin
                        p = exp_com.pop_front();
                        chk("commit_A_rd", 32'(commit_A_rd), 32'(p.a));
                        chk("commit_P_rd_new", 32'(commit_P_rd_new), 32'(p.pn));
                        chk("commit_P_rd_old", 32'(commit_P_rd_old), 32'(p.po));
                        chk("commit_wb_en", 32'(commit_wb_en), 32'(p.pn != 7'd0));
                    end
                end
                if (rollback_en_0 === 1'b1) begin
                    if (exp_sq.size() == 0) begin
                        chk("rollback0_unexpected", 32'(1), 32'(0));
                    end else begin
                        p = exp_sq.pop_front();
                        chk("rollback_A_rd_0", 32'(rollback_A_rd_0), 32'(p.a));
                        chk("rollback_P_rd_new_0", 32'(rollback_P_rd_new_0), 32'(p.pn));
                        chk("rollback_P_rd_old_0", 32'(rollback_P_rd_old_0), 32'(p.po));
                    end
                end
                if (rollback_en_1 === 1'b1) begin
                    if (exp_sq.size() == 0) begin
                        chk("rollback1_unexpected", 32'(1), 32'(0));
                    end else begin
                        p = exp_sq.pop_front();
                        chk("rollback_A_rd_1", 32'(rollback_A_rd_1), 32'(p.a));
                        chk("rollback_P_rd_new_1", 32'(rollback_P_rd_new_1), 32'(p.pn));
                        chk("rollback_P_rd_old_1", 32'(rollback_P_rd_old_1), 32'(p.po));
                    end
                end
            end
        end
    end

    function automatic pay_t pay_of(input ment_t m);
        pay_t p;
        p.a  = m.a;
        p.pn = m.pn;
        p.po = m.po;
        return p;
    endfunction

    // One clock of stimulus: predict this cycle's outputs, drive inputs, advance the model.
    task automatic step(input bit r, input bit dv, input logic [5:0] a, input logic [6:0] pn,
                        input logic [6:0] po, input bit wv, input logic [3:0] widx, input bit wm);
        stat_t s;
        ment_t e;
        int    n;
        int    k;
        int    sz;
        bit    com;
        bit    retgt;
        bit    nrb;
        @(negedge clk);
        sz      = mq.size();
        s.ready = !m_rb && (sz < 16);
        s.idx   = 4'(m_tail);
        com     = !m_rb && (sz > 0) && mq[0].done;
        n       = 0;
        if (m_rb) begin
            if (sz > 0 && mq[sz-1].seq > m_fs) n = 1;
            if (n == 1 && sz > 1 && mq[sz-2].seq > m_fs) n = 2;
        end
        s.cv  = com;
        s.en0 = (n >= 1);
        s.en1 = (n == 2);
        s.fd  = m_rb && (n == 0);
        exp_st.push_back(s);
        if (com) exp_com.push_back(pay_of(mq[0]));
        if (n >= 1) exp_sq.push_back(pay_of(mq[sz-1]));
        if (n == 2) exp_sq.push_back(pay_of(mq[sz-2]));

        rst           = r;
        disp_valid    = dv;
        disp_A_rd     = a;
        disp_P_rd_new = pn;
        disp_P_rd_old = po;
        wb_valid      = wv;
        wb_idx        = widx;
        wb_mispredict = wm;

        if (r) begin
            mq.delete();
            m_tail = 0;
            m_rb   = 0;
            return;
        end
        k = -1;
        if (wv) begin
            foreach (mq[j]) if (mq[j].idx == widx) k = j;
        end
        retgt = 0;
        nrb   = m_rb;
        if (k >= 0) begin
            mq[k].done = 1;
            if (wm) begin
                if (!m_rb) begin
                    m_fs = mq[k].seq;
                    nrb  = 1;
                end else if (mq[k].seq < m_fs) begin
                    m_fs  = mq[k].seq;
                    retgt = 1;
                end
            end
        end
        if (!m_rb) begin
            if (com) void'(mq.pop_front());
            if (dv && s.ready) begin
                e.seq  = m_seq;
                e.idx  = 4'(m_tail);
                e.a    = a;
                e.pn   = pn;
                e.po   = po;
                e.done = 0;
                mq.push_back(e);
                m_seq++;
                m_tail = (m_tail + 1) % 16;
            end
        end else begin
            repeat (n) void'(mq.pop_back());
            m_tail = (m_tail - n + 16) % 16;
            if (n == 0 && !retgt) nrb = 0;
        end
        m_rb = nrb;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) step(0, 0, 6'd0, 7'd0, 7'd0, 0, 4'd0, 0);
    endtask

    task automatic disp(input logic [5:0] a, input logic [6:0] pn, input logic [6:0] po);
        step(0, 1, a, pn, po, 0, 4'd0, 0);
    endtask

    task automatic wb(input logic [3:0] idx, input bit mis);
        step(0, 0, 6'd0, 7'd0, 7'd0, 1, idx, mis);
    endtask

    task automatic do_reset();
        step(1, 0, 6'd0, 7'd0, 7'd0, 0, 4'd0, 0);
        step(1, 0, 6'd0, 7'd0, 7'd0, 0, 4'd0, 0);
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && (mq.size() > 0 || m_rb); c++) begin
            if (mq.size() > 0 && !m_rb)
                wb(mq[$urandom_range(mq.size()-1)].idx, 0);
            else
                idle(1);
        end
    endtask

    initial begin
        logic [3:0] widx;
        rst = 1'b1; disp_valid = 0; disp_A_rd = 0; disp_P_rd_new = 0; disp_P_rd_old = 0;
        wb_valid = 0; wb_idx = 0; wb_mispredict = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Fill to full; the 17th dispatch is held.
        for (int i = 0; i < 17; i++) disp(6'(i), 7'(64 + i), 7'(i));
        idle(1);
        for (int i = 0; i < 16; i++) wb(4'(i), 0);
        idle(3);

        // Single retire with and without destination.
        do_reset();
        disp(6'd5, 7'd64, 7'd5);
        wb(4'd0, 0);
        idle(2);
        disp(6'd9, 7'd0, 7'd33);
        wb(4'd1, 0);
        idle(2);

        // Mispredict idx1 with six entries in flight.
        do_reset();
        for (int i = 0; i < 6; i++) disp(6'(10 + i), 7'(70 + i), 7'(20 + i));
        wb(4'd1, 1);
        idle(4);
        drain();

        // Mispredict idx3, then idx1 during the walk-back.
        do_reset();
        for (int i = 0; i < 6; i++) disp(6'(30 + i), 7'(90 + i), 7'(40 + i));
        wb(4'd3, 1);
        wb(4'd1, 1);
        idle(4);
        drain();

        // Wrap: head at 14, tail at 4, mispredict idx15.
        do_reset();
        for (int i = 0; i < 14; i++) disp(6'(i), 7'(i + 1), 7'(i));
        for (int i = 0; i < 14; i++) wb(4'(i), 0);
        idle(2);
        for (int i = 0; i < 6; i++) disp(6'(50 + i), 7'(100 + i), 7'(60 + i));
        wb(4'd15, 1);
        idle(4);
        drain();

        // Mispredict reported in the same cycle the branch retires.
        do_reset();
        for (int i = 0; i < 3; i++) disp(6'(i + 1), 7'(80 + i), 7'(i + 1));
        wb(4'd0, 0);
        wb(4'd0, 1);
        idle(4);

        // Reset in the middle of a walk-back.
        do_reset();
        for (int i = 0; i < 6; i++) disp(6'(i), 7'(i + 2), 7'(i));
        wb(4'd0, 1);
        idle(1);
        do_reset();
        idle(2);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(599) == 0) begin
                do_reset();
            end else begin
                if (mq.size() > 0 && $urandom_range(7) != 0)
                    widx = mq[$urandom_range(mq.size()-1)].idx;
                else
                    widx = 4'($urandom_range(15));
                step(0, $urandom_range(3) != 0, 6'($urandom), 
                     ($urandom_range(7) == 0) ? 7'd0 : 7'($urandom),
                     7'($urandom), $urandom_range(1) == 1, widx, $urandom_range(15) == 0);
            end
        end
        drain();
        idle(2);
        @(negedge clk);
        #2;
        chk("commit_queue_empty", 32'(exp_com.size()), 32'(0));
        chk("squash_queue_empty", 32'(exp_sq.size()), 32'(0));
        chk("status_queue_empty", 32'(exp_st.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
